// File: rtl/data_memory_pkg.sv
// Shared definitions for the data memory: MMIO window base, register map and
// STATUS bit position. The MMIO window is only decoded when DMEM_MMIO_EN is defined.
package data_memory_pkg;

  // Base byte address of the 16-byte memory-mapped I/O window.
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_FFF0;

  // Register selected by addr[3:2] inside the window.
  typedef enum logic [1:0] {
    REG_CYCLES = 2'd0,
    REG_IO_OUT = 2'd1,
    REG_STATUS = 2'd2,
    REG_RSVD   = 2'd3
  } mmio_reg_e;

  // Bit of STATUS that mirrors (and W1C-clears) misalign_err.
  localparam int STATUS_ERR_BIT = 0;

  // True when a byte address falls inside the MMIO window.
  function automatic logic in_mmio_window(input logic [31:0] a);
    return a[31:4] == MMIO_BASE[31:4];
  endfunction

endpackage

// File: rtl/dmem_mmio_regs.sv
// MMIO register block: free-running cycle counter, io_out register with its
// one-cycle valid pulse, and the W1C clear request for the STATUS error bit.
// Instantiated by data_memory only when DMEM_MMIO_EN is defined.
module dmem_mmio_regs
  import data_memory_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  mmio_reg_e   reg_sel,
  input  logic [31:0] write_data,
  input  logic        misalign_err,
  output logic [31:0] rdata,
  output logic [31:0] io_out,
  output logic        io_out_valid,
  output logic        status_clear
);

  logic [31:0] cycles;
  logic        io_wr;

  assign io_wr = wr_en && (reg_sel == REG_IO_OUT);

  // Free-running cycle counter, wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cycles <= '0;
    else     cycles <= cycles + 32'd1;
  end

  // io_out register; valid pulses for the single cycle after each write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_out       <= '0;
      io_out_valid <= 1'b0;
    end else begin
      io_out_valid <= io_wr;
      if (io_wr) io_out <= write_data;
    end
  end

  // Writing 1 to the STATUS error bit requests a clear of the sticky flag.
  always_comb begin
    status_clear = 1'b0;
    if (wr_en && (reg_sel == REG_STATUS) && write_data[STATUS_ERR_BIT])
      status_clear = 1'b1;
  end

  // Register read mux; reserved slot and unused STATUS bits read as zero.
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CYCLES: rdata = cycles;
      REG_IO_OUT: rdata = io_out;
      REG_STATUS: rdata[STATUS_ERR_BIT] = misalign_err;
      default:    rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory for the CPU memory stage. Combinational read,
// single-edge write, word-alignment checking with a sticky error flag.
// Optional MMIO window enabled by defining DMEM_MMIO_EN.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        read_en,
  input  logic        write_en,
  output logic [31:0] read_data,
  output logic        misalign_err,
  output logic [31:0] io_out,
  output logic        io_out_valid
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          aligned;
  logic          misaligned;
  logic          in_window;
  logic          ram_we;
  logic          status_clear;
  logic          unused_hi;

  // Upper address bits only alias onto RAM; they carry no information here.
  assign unused_hi  = ^addr[31:AW+2];

  assign idx        = addr[AW+1:2];
  assign aligned    = (addr[1:0] == 2'b00);
  assign misaligned = (read_en || write_en) && !aligned;
  assign ram_we     = write_en && aligned && !in_window;

`ifdef DMEM_MMIO_EN
  logic [31:0] mmio_rdata;

  assign in_window = in_mmio_window(addr);

  dmem_mmio_regs u_mmio_regs (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (write_en && aligned && in_window),
    .reg_sel      (mmio_reg_e'(addr[3:2])),
    .write_data   (write_data),
    .misalign_err (misalign_err),
    .rdata        (mmio_rdata),
    .io_out       (io_out),
    .io_out_valid (io_out_valid),
    .status_clear (status_clear)
  );
`else
  assign in_window    = 1'b0;
  assign io_out       = '0;
  assign io_out_valid = 1'b0;
  assign status_clear = 1'b0;
`endif

  // RAM array: cleared by reset, written at the edge for aligned non-MMIO stores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (ram_we) begin
      mem[idx] <= write_data;
    end
  end

  // Sticky misalignment flag; a new error beats a same-cycle W1C clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               misalign_err <= 1'b0;
    else if (misaligned)   misalign_err <= 1'b1;
    else if (status_clear) misalign_err <= 1'b0;
  end

  // Combinational read mux: old RAM contents are visible during a same-word write.
  always_comb begin
    read_data = '0;
    if (read_en && aligned) begin
`ifdef DMEM_MMIO_EN
      if (in_window) read_data = mmio_rdata;
      else           read_data = mem[idx];
`else
      read_data = mem[idx];
`endif
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory. Expected read data is pushed to a
// scoreboard queue as each access is driven and popped when read_data is
// sampled; a small reference model tracks RAM, the error flag and io_out.
module tb_data_memory;
  import data_memory_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        read_en;
  logic        write_en;
  logic [31:0] read_data;
  logic        misalign_err;
  logic [31:0] io_out;
  logic        io_out_valid;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model_mem [256];
  logic        model_err;
  logic [31:0] model_io;
  logic        model_valid;
  logic [31:0] last_rd;

  data_memory #(.DEPTH(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .write_data   (write_data),
    .read_en      (read_en),
    .write_en     (write_en),
    .read_data    (read_data),
    .misalign_err (misalign_err),
    .io_out       (io_out),
    .io_out_valid (io_out_valid)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic win(input logic [31:0] a);
`ifdef DMEM_MMIO_EN
    return in_mmio_window(a);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic re);
    logic [31:0] r;
    r = '0;
    if (re && a[1:0] == 2'b00) begin
      if (!win(a)) r = model_mem[a[9:2]];
      else if (a[3:2] == 2'd1) r = model_io;
      else if (a[3:2] == 2'd2) r = {31'b0, model_err};
      else r = '0;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    model_err   = 1'b0;
    model_io    = '0;
    model_valid = 1'b0;
  endtask

  // Driver: one access per cycle, driven after the falling edge and sampled
  // 1 ns later; the model is advanced to account for the following rising edge.
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic re,
                      input logic we, input bit rd_chk, input string tag);
    logic [31:0] e;
    logic        io_wr;
    @(negedge clk);
    addr = a; write_data = wd; read_en = re; write_en = we;
    exp_q.push_back(model_read(a, re));
    #1;
    e = exp_q.pop_front();
    last_rd = read_data;
    if (rd_chk) check({tag, ".rd"}, read_data, e);
    check({tag, ".err"}, {31'b0, misalign_err}, {31'b0, model_err});
    check({tag, ".io"}, io_out, model_io);
    check({tag, ".iov"}, {31'b0, io_out_valid}, {31'b0, model_valid});
    io_wr = 1'b0;
    if ((re || we) && a[1:0] != 2'b00) begin
      model_err = 1'b1;
    end else if (we) begin
      if (!win(a)) model_mem[a[9:2]] = wd;
      else if (a[3:2] == 2'd1) begin model_io = wd; io_wr = 1'b1; end
      else if (a[3:2] == 2'd2 && wd[0]) model_err = 1'b0;
    end
    model_valid = io_wr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, "idle");
  endtask

  initial begin
    logic [31:0] c1;
    logic [31:0] ra;
    logic [1:0]  off;

    rst = 1'b1; addr = '0; write_data = '0; read_en = 1'b0; write_en = 1'b0;
    model_reset();
    last_rd = '0;

    // Reset state
    #3;
    check("rst.rd",  read_data, 32'h0);
    check("rst.err", {31'b0, misalign_err}, 32'h0);
    check("rst.io",  io_out, 32'h0);
    check("rst.iov", {31'b0, io_out_valid}, 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;

    // 1. write then read back; neighbour word still zero
    step(32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, "t1.wr");
    step(32'h10, 32'h0, 1'b1, 1'b0, 1'b1, "t1.rd");
    check("t1.const", last_rd, 32'hDEAD_BEEF);
    step(32'h14, 32'h0, 1'b1, 1'b0, 1'b1, "t1.rd14");

    // 2. same-cycle read and write: old value visible, new value next cycle
    step(32'h20, 32'h5, 1'b0, 1'b1, 1'b1, "t2.pre");
    step(32'h20, 32'h1234, 1'b1, 1'b1, 1'b1, "t2.rw");
    check("t2.old", last_rd, 32'h5);
    step(32'h20, 32'h0, 1'b1, 1'b0, 1'b1, "t2.new");
    check("t2.newc", last_rd, 32'h1234);

    // 3. misaligned write is suppressed, error is sticky, misaligned read is zero
    step(32'h0, 32'h99, 1'b0, 1'b1, 1'b1, "t3.w0");
    step(32'h3, 32'hAA, 1'b0, 1'b1, 1'b1, "t3.mis");
    step(32'h0, 32'h0, 1'b1, 1'b0, 1'b1, "t3.rd0");
    check("t3.w0c", last_rd, 32'h99);
    check("t3.errc", {31'b0, misalign_err}, 32'h1);
    step(32'h2, 32'h0, 1'b1, 1'b0, 1'b1, "t3.rd2");
    idle(3);

    // 4. aliasing: 0x400 wraps onto word 0; window address handled per build
    step(32'h400, 32'h77, 1'b0, 1'b1, 1'b1, "t4.wr");
    step(32'h0, 32'h0, 1'b1, 1'b0, 1'b1, "t4.rd");
    check("t4.wrap", last_rd, 32'h77);
    step(32'hFFFF_FFF0, 32'h55, 1'b0, 1'b1, 1'b1, "t4.wwin");
    step(32'h3F0, 32'h0, 1'b1, 1'b0, 1'b1, "t4.rwin");

    // Random traffic over the low 64 words, occasional misalignment
    for (int i = 0; i < 40; i++) begin
      off = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ra  = {22'b0, 8'($urandom_range(0, 63)), off};
      step(ra, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, "rand");
    end

    // 5. io_out and the MMIO window
    step(32'hFFFF_FFF4, 32'h00C0_FFEE, 1'b0, 1'b1, 1'b1, "t5.io");
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, "t5.v1");
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, "t5.v0");
`ifdef DMEM_MMIO_EN
    check("t5.ioc", io_out, 32'h00C0_FFEE);
    step(32'hFFFF_FFF0, 32'h0, 1'b1, 1'b0, 1'b0, "t5.c1");
    c1 = last_rd;
    idle(9);
    step(32'hFFFF_FFF0, 32'h0, 1'b1, 1'b0, 1'b0, "t5.c2");
    check("t5.cyc", last_rd - c1, 32'd10);
    step(32'hFFFF_FFFC, 32'h1, 1'b1, 1'b1, 1'b1, "t5.rsvd");
    step(32'h1, 32'h0, 1'b1, 1'b0, 1'b1, "t6.mis");
    step(32'hFFFF_FFF8, 32'h0, 1'b1, 1'b0, 1'b1, "t6.st");
    step(32'hFFFF_FFF8, 32'h1, 1'b0, 1'b1, 1'b1, "t6.w1c");
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, "t6.clr");
    check("t6.clrc", {31'b0, misalign_err}, 32'h0);
`else
    check("t5.off", io_out, 32'h0);
`endif

    // 6. asynchronous reset in the middle of a write
    step(32'h40, 32'h1111_1111, 1'b0, 1'b1, 1'b1, "t6.pre");
    step(32'h5, 32'h0, 1'b1, 1'b0, 1'b1, "t6.mis2");
    @(negedge clk);
    addr = 32'h40; write_data = 32'hBAD0_BAD0; read_en = 1'b1; write_en = 1'b1;
    #1 check("t6.before", read_data, 32'h1111_1111);
    #1 rst = 1'b1;
    #1;
    check("t6.rrd",  read_data, 32'h0);
    check("t6.rerr", {31'b0, misalign_err}, 32'h0);
    check("t6.rio",  io_out, 32'h0);
    check("t6.riov", {31'b0, io_out_valid}, 32'h0);
    @(negedge clk);
    read_en = 1'b0; write_en = 1'b0;
    #1 rst = 1'b0;
    model_reset();
    step(32'h40, 32'h0, 1'b1, 1'b0, 1'b1, "t6.post40");
    step(32'h10, 32'h0, 1'b1, 1'b0, 1'b1, "t6.post10");
    step(32'h20, 32'h0, 1'b1, 1'b0, 1'b1, "t6.post20");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
